// File: rtl/bsearch_pkg.sv
// Shared types and defaults for the scheduled binary-search engine.
package bsearch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the slot just after ptr has highest priority.
module rr_arbiter
  import bsearch_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  logic           found_s;
  logic [IDW-1:0] idx_s;

  // Walk the slots after ptr, wrapping, and take the first asserted request.
  always_comb begin
    grant   = '0;
    id      = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_s = IDW'((int'(ptr) + off) % NREQ);
      if (en && !found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        id           = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/bsearch_rr_sched.sv
// Round-robin scheduled binary-search engine over a sorted single-read-port table.
module bsearch_rr_sched
  import bsearch_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        key,
  output logic [NREQ-1:0]           grant,
  output logic                      mem_rd,
  output logic [AW-1:0]             mem_addr,
  input  logic [DW-1:0]             mem_rdata,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic                      rsp_found,
  output logic [AW:0]               rsp_index
);

  localparam int IDW = id_width(NREQ);
  localparam logic [AW-1:0] TOP_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW:0]   ONE_W    = (AW+1)'(1);

  state_t         state_r, state_s;
  logic [IDW-1:0] ptr_r, win_id_s, id_r;
  logic           arb_en_s, hit_s, less_s, last_s;
  logic [DW-1:0]  key_r;
  logic [AW-1:0]  low_r, high_r, low_s, high_s, mid_s;
  logic [AW:0]    sum_s, index_s;
  logic           found_s;

  // Arbitration is only live in IDLE and never while reset is asserted.
  assign arb_en_s = (state_r == ST_IDLE) && rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .en    (arb_en_s),
    .grant (grant),
    .id    (win_id_s)
  );

  // mem_addr holds the current probe address, so it doubles as mid in COMPARE.
  assign hit_s  = (mem_rdata == key_r);
  assign less_s = (key_r < mem_rdata);
  assign last_s = hit_s || (less_s ? (mem_addr == low_r) : (mem_addr == high_r));

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (|grant) state_s = ST_ISSUE; else state_s = ST_IDLE;
      ST_ISSUE:   state_s = ST_COMPARE;
      ST_COMPARE: if (last_s) state_s = ST_RESP; else state_s = ST_ISSUE;
      ST_RESP:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Search window update and result selection.
  always_comb begin
    low_s   = low_r;
    high_s  = high_r;
    found_s = 1'b0;
    index_s = {1'b0, mem_addr};
    case (state_r)
      ST_IDLE: begin
        if (|grant) begin
          low_s  = '0;
          high_s = TOP_ADDR;
        end else begin
          low_s  = low_r;
        end
      end
      ST_COMPARE: begin
        if (hit_s) begin
          found_s = 1'b1;
        end else if (less_s) begin
          if (mem_addr == low_r) index_s = {1'b0, low_r};
          else                   high_s  = mem_addr - ONE_A;
        end else begin
          if (mem_addr == high_r) index_s = {1'b0, mem_addr} + ONE_W;
          else                    low_s   = mem_addr + ONE_A;
        end
      end
      default: found_s = 1'b0;
    endcase
  end

  // Midpoint at AW+1 bits so low+high cannot wrap.
  assign sum_s = {1'b0, low_s} + {1'b0, high_s};
  assign mid_s = AW'(sum_s >> 1);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= IDW'(NREQ - 1);
      key_r     <= '0;
      id_r      <= '0;
      low_r     <= '0;
      high_r    <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_found <= 1'b0;
      rsp_index <= '0;
    end else begin
      state_r   <= state_s;
      low_r     <= low_s;
      high_r    <= high_s;
      mem_rd    <= (state_s == ST_ISSUE);
      busy      <= (state_s != ST_IDLE);
      rsp_valid <= (state_s == ST_RESP);
      if (|grant) begin
        key_r <= key[int'(win_id_s)*DW +: DW];
        id_r  <= win_id_s;
        ptr_r <= win_id_s;
      end
      if (state_s == ST_ISSUE) mem_addr <= mid_s;
      if (state_s == ST_RESP) begin
        rsp_id    <= id_r;
        rsp_found <= found_s;
        rsp_index <= index_s;
      end
    end
  end

endmodule

// File: tb/tb_bsearch_rr_sched.sv
// Self-checking bench for bsearch_rr_sched against a table of mem[i] = 2*i+1.
module tb_bsearch_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] key;
  logic [3:0]  grant;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_found;
  logic [4:0]  rsp_index;
  logic [7:0]  kv [4];

  int checks = 0;
  int errors = 0;
  int ptr_m  = 3;
  int probes[$];
  int exp_probes[$];

  bsearch_rr_sched #(.NREQ(4), .DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .key(key), .grant(grant),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_found(rsp_found), .rsp_index(rsp_index)
  );

  always #5 clk = ~clk;

  always_comb key = {kv[3], kv[2], kv[1], kv[0]};

  // Table RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_rdata <= 8'(2 * int'(mem_addr) + 1);
  end

  // Probe address log.
  always @(negedge clk) begin
    if (mem_rd === 1'b1) probes.push_back(int'(mem_addr));
  end

  function automatic int pick(input logic [3:0] r, input int p);
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (p + off) % 4;
      if (r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Reference: found/insertion point by scanning the table; probe list by bisecting ints.
  function automatic void ref_search(input int kk, output bit f, output int idx, output int k);
    int lo, hi, mid, d;
    bit done;
    f = 1'b0; idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (2*i+1 < kk) idx++;
      if (2*i+1 == kk) f = 1'b1;
    end
    exp_probes.delete();
    lo = 0; hi = 15; k = 0; done = 1'b0;
    while (!done) begin
      mid = (lo + hi) / 2;
      exp_probes.push_back(mid);
      k++;
      d = 2*mid + 1;
      if (d == kk) done = 1'b1;
      else if (kk < d) begin if (mid == lo) done = 1'b1; else hi = mid - 1; end
      else begin if (mid == hi) done = 1'b1; else lo = mid + 1; end
    end
  endfunction

  task automatic run_one(input bit drop, output int gwait, output int lat);
    int exp_id, idx_e, k_e;
    bit f_e, pok;
    logic [3:0] eg;
    exp_id = pick(req, ptr_m);
    gwait = 0; lat = 0;
    if (exp_id < 0) begin
      checks++; errors++;
      $display("FAIL run_one: no request pending, got req %b expected nonzero", req);
      return;
    end
    eg = 4'b0001 << exp_id;
    @(negedge clk);
    while (grant == 4'b0000 && gwait < 20) begin @(negedge clk); gwait++; end
    checks++;
    if (grant !== eg) begin
      errors++;
      $display("FAIL grant: got %b expected %b", grant, eg);
      return;
    end
    ptr_m = exp_id;
    probes.delete();
    ref_search(int'(kv[exp_id]), f_e, idx_e, k_e);
    if (drop) begin @(posedge clk); #1; req[exp_id] = 1'b0; end
    while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 2*k_e + 1) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, 2*k_e+1); end
    checks++;
    if (rsp_id !== 2'(exp_id)) begin errors++; $display("FAIL rsp_id: got %0d expected %0d", rsp_id, exp_id); end
    checks++;
    if (rsp_found !== f_e) begin errors++; $display("FAIL rsp_found key %0d: got %b expected %b", kv[exp_id], rsp_found, f_e); end
    checks++;
    if (rsp_index !== 5'(idx_e)) begin errors++; $display("FAIL rsp_index key %0d: got %0d expected %0d", kv[exp_id], rsp_index, idx_e); end
    pok = (probes.size() == exp_probes.size());
    if (pok) foreach (probes[i]) if (probes[i] != exp_probes[i]) pok = 1'b0;
    checks++;
    if (!pok) begin errors++; $display("FAIL probes key %0d: got %0d probes expected %0d", kv[exp_id], probes.size(), exp_probes.size()); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0; req = 4'b0000;
    @(posedge clk); #1; rst = 1'b1; ptr_m = 3;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0000;
    for (int i = 0; i < 4; i++) kv[i] = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({grant, mem_rd, busy, rsp_valid} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {grant, mem_rd, busy, rsp_valid}); end
    checks++;
    if (mem_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++;
    if ({rsp_id, rsp_found, rsp_index} !== 8'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0", {rsp_id, rsp_found, rsp_index}); end
    @(posedge clk); #1; rst = 1'b1; ptr_m = 3;
  endtask

  task automatic test_directed();
    int rq [6] = '{0, 2, 2, 2, 2, 2};
    int kk [6] = '{15, 31, 1, 0, 40, 14};
    int fe [6] = '{1, 1, 1, 0, 0, 0};
    int ie [6] = '{7, 15, 0, 0, 16, 7};
    int ke [6] = '{1, 5, 4, 4, 5, 4};
    int gw, lat;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      kv[rq[t]] = 8'(kk[t]);
      req = 4'b0001 << rq[t];
      run_one(1'b1, gw, lat);
      checks++;
      if (rsp_found !== 1'(fe[t]) || rsp_index !== 5'(ie[t]) || lat != 2*ke[t]+1) begin
        errors++;
        $display("FAIL directed key %0d: got found %b index %0d lat %0d expected %0d %0d %0d",
                 kk[t], rsp_found, rsp_index, lat, fe[t], ie[t], 2*ke[t]+1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gw, lat;
    do_reset();
    kv[0] = 8'd9; kv[1] = 8'd20; kv[2] = 8'd33; kv[3] = 8'd2;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      run_one(1'b0, gw, lat);
      checks++;
      if (rsp_id !== 2'(i) || gw != 0) begin
        errors++;
        $display("FAIL rr_order step %0d: got id %0d wait %0d expected id %0d wait 0", i, rsp_id, gw, i);
      end
    end
    @(posedge clk); #1; req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      run_one(1'b0, gw, lat);
      checks++;
      if (rsp_id !== 2'(2*i)) begin errors++; $display("FAIL rr_0101 step %0d: got id %0d expected %0d", i, rsp_id, 2*i); end
    end
  endtask

  task automatic test_reset_mid();
    int gw, lat;
    @(posedge clk); #1; req = 4'b0001; kv[0] = 8'd14;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b expected 0001", grant); end
    @(posedge clk); #1; req = 4'b0000;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    @(posedge clk); #1; req = 4'b0010; kv[1] = 8'd27;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, mem_rd, grant} !== 7'b0) begin
      errors++; $display("FAIL mid_reset_out: got %b expected 0", {rsp_valid, busy, mem_rd, grant});
    end
    @(posedge clk); #1; rst = 1'b1; ptr_m = 3;
    run_one(1'b1, gw, lat);
    checks++;
    if (gw != 0) begin errors++; $display("FAIL mid_release_wait: got %0d expected 0", gw); end
  endtask

  task automatic test_pulse_busy();
    int gw, lat, bad;
    @(posedge clk); #1; req = 4'b0001; kv[0] = 8'd14; kv[3] = 8'd5;
    fork
      run_one(1'b1, gw, lat);
      begin
        repeat (3) @(posedge clk);
        #1 req[3] = 1'b1;
        @(posedge clk);
        #1 req[3] = 1'b0;
      end
    join
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant[3] === 1'b1 || rsp_valid === 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pulse_ignored: got %0d events expected 0", bad); end
  endtask

  task automatic test_random();
    int gw, lat;
    logic [3:0] nm;
    for (int it = 0; it < 30; it++) begin
      @(posedge clk); #1;
      if (req == 4'b0000 || $urandom_range(0, 1) == 1) begin
        nm = 4'($urandom_range(1, 15)) & ~req;
        for (int i = 0; i < 4; i++) if (nm[i]) kv[i] = 8'($urandom_range(0, 40));
        req = req | nm;
      end
      run_one(1'b1, gw, lat);
    end
    @(posedge clk); #1; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_pulse_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
